// File: rtl/adbg_or1k_mp_status_reg.sv
// adbg_or1k_mp_status_reg: per-core stall, breakpoint-flag and reset-pulse control for multiple cores
module adbg_or1k_mp_status_reg #(
    parameter int CPU_COUNT     = 4,
    parameter int RST_PULSE_LEN = 16,
    parameter int BP_STALL_ALL  = 0
) (
    input  logic                   cpu_clk_i,
    input  logic                   rst_i,
    input  logic                   we_i,
    input  logic [3*CPU_COUNT-1:0] data_i,
    input  logic [CPU_COUNT-1:0]   bp_i,
    output logic [CPU_COUNT-1:0]   cpu_stall_o,
    output logic [CPU_COUNT-1:0]   cpu_rst_o,
    output logic [3*CPU_COUNT-1:0] ctrl_reg_o
);
    localparam int N  = CPU_COUNT;
    localparam int CW = $clog2(RST_PULSE_LEN + 1);

    typedef enum logic {IDLE, RESET} state_t;

    logic [N-1:0] stall_reg, bp_hit, rst_active;
    logic         any_bp;

    assign any_bp     = |bp_i;
    assign ctrl_reg_o = {bp_hit, rst_active, stall_reg};

    for (genvar i = 0; i < N; i++) begin : g_core
        state_t        state, state_nxt;
        logic [CW-1:0] cnt, cnt_nxt;
        logic          stall_q, stall_nxt, hit_q, hit_nxt, rst_q;
        logic          bp_src, enter;

        // A core in reset ignores breakpoints for stalling purposes
        assign bp_src = ((BP_STALL_ALL != 0) ? any_bp : bp_i[i]) & (state == IDLE);
        assign enter  = (state == IDLE) & we_i & data_i[N+i];

        // Next-state for the reset FSM, its counter and the per-core status bits
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            if (state == IDLE) begin
                if (enter) begin
                    state_nxt = RESET;
                    cnt_nxt   = CW'(RST_PULSE_LEN);
                end
            end else begin
                cnt_nxt = cnt - 1'b1;
                if (cnt == CW'(1))
                    state_nxt = IDLE;
            end
            stall_nxt = (bp_src & ~enter) ? 1'b1 : we_i ? data_i[i] : stall_q;
            hit_nxt   = enter ? 1'b0 : bp_i[i] ? 1'b1 : (we_i & data_i[2*N+i]) ? 1'b0 : hit_q;
        end

        // State registers; cpu_rst_o is rst_active delayed by one cycle
        always_ff @(posedge cpu_clk_i or posedge rst_i) begin
            if (rst_i) begin
                state   <= IDLE;
                cnt     <= '0;
                stall_q <= 1'b0;
                hit_q   <= 1'b0;
                rst_q   <= 1'b0;
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                stall_q <= stall_nxt;
                hit_q   <= hit_nxt;
                rst_q   <= (state == RESET);
            end
        end

        assign stall_reg[i]   = stall_q;
        assign bp_hit[i]      = hit_q;
        assign rst_active[i]  = (state == RESET);
        assign cpu_rst_o[i]   = rst_q;
        assign cpu_stall_o[i] = bp_src | stall_q | rst_active[i];
    end
endmodule

// File: tb/tb_adbg_or1k_mp_status_reg.sv
// tb_adbg_or1k_mp_status_reg: directed checks of stall, breakpoint flags and reset pulses
module tb_adbg_or1k_mp_status_reg;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           we = 1'b0;
    logic [3*N-1:0] data = '0;
    logic [N-1:0]   bp = '0;
    logic [N-1:0]   stall0, rst0, stall1, rst1;
    logic [3*N-1:0] ctrl0, ctrl1;
    int             errors = 0;
    int             checks = 0;

    always #5 clk = ~clk;

    adbg_or1k_mp_status_reg #(.CPU_COUNT(N), .RST_PULSE_LEN(3), .BP_STALL_ALL(0)) u0 (
        .cpu_clk_i(clk), .rst_i(rst), .we_i(we), .data_i(data), .bp_i(bp),
        .cpu_stall_o(stall0), .cpu_rst_o(rst0), .ctrl_reg_o(ctrl0)
    );

    adbg_or1k_mp_status_reg #(.CPU_COUNT(N), .RST_PULSE_LEN(3), .BP_STALL_ALL(1)) u1 (
        .cpu_clk_i(clk), .rst_i(rst), .we_i(we), .data_i(data), .bp_i(bp),
        .cpu_stall_o(stall1), .cpu_rst_o(rst1), .ctrl_reg_o(ctrl1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3*N-1:0] d);
        we   = 1'b1;
        data = d;
        step();
        we   = 1'b0;
        data = '0;
    endtask

    task automatic test_reset();
        bp = 4'b0010;
        step();
        step();
        checks++; if (ctrl0 !== 12'h000) begin errors++; $display("FAIL reset_ctrl0 got=%h exp=000", ctrl0); end
        checks++; if (ctrl1 !== 12'h000) begin errors++; $display("FAIL reset_ctrl1 got=%h exp=000", ctrl1); end
        checks++; if (rst0 !== 4'b0000) begin errors++; $display("FAIL reset_rst0 got=%b exp=0000", rst0); end
        checks++; if (stall0 !== 4'b0010) begin errors++; $display("FAIL reset_stall0_bp got=%b exp=0010", stall0); end
        checks++; if (stall1 !== 4'b1111) begin errors++; $display("FAIL reset_stall1_bp got=%b exp=1111", stall1); end
        bp  = '0;
        rst = 1'b0;
        step();
        checks++; if (stall0 !== 4'b0000) begin errors++; $display("FAIL post_reset_stall0 got=%b exp=0000", stall0); end
    endtask

    task automatic test_bp_stall();
        bp = 4'b0100;
        #1;
        checks++; if (stall0 !== 4'b0100) begin errors++; $display("FAIL bp_same_cycle0 got=%b exp=0100", stall0); end
        checks++; if (stall1 !== 4'b1111) begin errors++; $display("FAIL bp_same_cycle1 got=%b exp=1111", stall1); end
        step();
        bp = '0;
        #1;
        checks++; if (stall0 !== 4'b0100) begin errors++; $display("FAIL bp_held0 got=%b exp=0100", stall0); end
        checks++; if (ctrl0 !== 12'h404) begin errors++; $display("FAIL bp_ctrl0 got=%h exp=404", ctrl0); end
        checks++; if (ctrl1 !== 12'h40F) begin errors++; $display("FAIL bp_ctrl1 got=%h exp=40f", ctrl1); end
    endtask

    task automatic test_clear();
        write(12'h400);
        checks++; if (stall0 !== 4'b0000) begin errors++; $display("FAIL clear_stall0 got=%b exp=0000", stall0); end
        checks++; if (ctrl0 !== 12'h000) begin errors++; $display("FAIL clear_ctrl0 got=%h exp=000", ctrl0); end
        checks++; if (ctrl1 !== 12'h000) begin errors++; $display("FAIL clear_ctrl1 got=%h exp=000", ctrl1); end
        we   = 1'b1;
        data = 12'h400;
        bp   = 4'b0100;
        step();
        we   = 1'b0;
        data = '0;
        bp   = '0;
        #1;
        checks++; if (ctrl0 !== 12'h404) begin errors++; $display("FAIL set_wins_ctrl0 got=%h exp=404", ctrl0); end
        checks++; if (stall0 !== 4'b0100) begin errors++; $display("FAIL set_wins_stall0 got=%b exp=0100", stall0); end
        checks++; if (ctrl1 !== 12'h40F) begin errors++; $display("FAIL set_wins_ctrl1 got=%h exp=40f", ctrl1); end
        write(12'hF00);
        checks++; if (ctrl0 !== 12'h000) begin errors++; $display("FAIL clear_all_ctrl0 got=%h exp=000", ctrl0); end
    endtask

    task automatic test_bp_all();
        bp = 4'b0001;
        #1;
        checks++; if (stall1 !== 4'b1111) begin errors++; $display("FAIL bp_all_same_cycle got=%b exp=1111", stall1); end
        checks++; if (stall0 !== 4'b0001) begin errors++; $display("FAIL bp_one_same_cycle got=%b exp=0001", stall0); end
        step();
        bp = '0;
        #1;
        checks++; if (ctrl1 !== 12'h10F) begin errors++; $display("FAIL bp_all_ctrl1 got=%h exp=10f", ctrl1); end
        checks++; if (ctrl0 !== 12'h101) begin errors++; $display("FAIL bp_one_ctrl0 got=%h exp=101", ctrl0); end
        checks++; if (stall1 !== 4'b1111) begin errors++; $display("FAIL bp_all_held got=%b exp=1111", stall1); end
        write(12'hF00);
    endtask

    task automatic test_write_stall();
        write(12'h00A);
        checks++; if (ctrl0 !== 12'h00A) begin errors++; $display("FAIL wr_a_ctrl0 got=%h exp=00a", ctrl0); end
        checks++; if (stall0 !== 4'b1010) begin errors++; $display("FAIL wr_a_stall0 got=%b exp=1010", stall0); end
        write(12'h005);
        checks++; if (ctrl1 !== 12'h005) begin errors++; $display("FAIL wr_5_ctrl1 got=%h exp=005", ctrl1); end
        checks++; if (stall1 !== 4'b0101) begin errors++; $display("FAIL wr_5_stall1 got=%b exp=0101", stall1); end
    endtask

    task automatic test_rst_pulse();
        logic [3*N-1:0] exp_ctrl;
        logic [N-1:0]   exp_rst, exp_stall;
        write(12'h00F);
        bp = 4'b0010;
        step();
        bp = '0;
        #1;
        checks++; if (ctrl0 !== 12'h20F) begin errors++; $display("FAIL pre_pulse_ctrl0 got=%h exp=20f", ctrl0); end
        we   = 1'b1;
        data = 12'h02D;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) begin
                we   = 1'b1;
                data = 12'h02D;
            end else begin
                we   = 1'b0;
                data = '0;
            end
            exp_rst   = (k >= 2 && k <= 4) ? 4'b0010 : 4'b0000;
            exp_ctrl  = {4'b0000, (k <= 3) ? 4'b0010 : 4'b0000, 4'b1101};
            exp_stall = (k <= 3) ? 4'b1111 : 4'b1101;
            checks++; if (rst0 !== exp_rst) begin errors++; $display("FAIL pulse_rst k=%0d got=%b exp=%b", k, rst0, exp_rst); end
            checks++; if (ctrl0 !== exp_ctrl) begin errors++; $display("FAIL pulse_ctrl k=%0d got=%h exp=%h", k, ctrl0, exp_ctrl); end
            checks++; if (stall0 !== exp_stall) begin errors++; $display("FAIL pulse_stall k=%0d got=%b exp=%b", k, stall0, exp_stall); end
        end
    endtask

    task automatic test_async_reset();
        int n;
        write(12'h01F);
        step();
        checks++; if (rst0 !== 4'b0001) begin errors++; $display("FAIL mid_pulse_rst0 got=%b exp=0001", rst0); end
        #3 rst = 1'b1;
        #1;
        checks++; if (rst0 !== 4'b0000) begin errors++; $display("FAIL async_rst0 got=%b exp=0000", rst0); end
        checks++; if (ctrl0 !== 12'h000) begin errors++; $display("FAIL async_ctrl0 got=%h exp=000", ctrl0); end
        checks++; if (ctrl1 !== 12'h000) begin errors++; $display("FAIL async_ctrl1 got=%h exp=000", ctrl1); end
        checks++; if (stall0 !== 4'b0000) begin errors++; $display("FAIL async_stall0 got=%b exp=0000", stall0); end
        #2 rst = 1'b0;
        step();
        write(12'h010);
        checks++; if (ctrl0 !== 12'h010) begin errors++; $display("FAIL restart_ctrl0 got=%h exp=010", ctrl0); end
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (rst0[0]) n++;
            step();
        end
        checks++; if (n != 3) begin errors++; $display("FAIL restart_len got=%0d exp=3", n); end
    endtask

    initial begin
        test_reset();
        test_bp_stall();
        test_clear();
        test_bp_all();
        test_write_stall();
        test_rst_pulse();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
